seq_detect_n: RTL and testbench
===============================

Name: seq_detect_n

Overview:
- Parametrised serial sequence detector; successor to the fixed 3-bit "111" detector used in the lab FSM blocks.
- Detects a programmable N-bit pattern on a 1-bit serial input qualified by a valid strobe.
- Overlapping and non-overlapping detection are selectable at run time.
- Exposes internal state (fill level, window) for bench observation. Sits between a serial bit source and downstream event logic.

Parameters:
- PATTERN_W, 3, pattern length N in bits (2..16).
- PATTERN, 3'b111, reset value of the pattern register; the MSB is the first bit received.
- COUNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- s  input  1  serial data bit.
- s_valid  input  1  s is sampled only when this is 1.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PATTERN_W  new pattern; MSB is the first bit.
- y  output  1  match pulse, registered.
- fill  output  FW  number of valid bits held in the window, saturating at N; FW = $clog2(PATTERN_W+1).
- window  output  PATTERN_W  last N sampled bits; the newest bit is in the LSB.
- match_count  output  COUNT_W  saturating count of matches.

Behaviour:
- Reset (reset=0, asynchronous): y=0, fill=0, window=0, match_count=0, pattern register=PATTERN. Takes effect immediately, regardless of clk, including mid-sequence.
- Priority per edge: pat_load > s_valid > idle.
- pat_load=1: pattern register <= pat_in, fill <= 0, window <= 0, y <= 0. Any s in the same cycle is discarded. match_count is unchanged.
- s_valid=1, pat_load=0: window <= {window[N-2:0], s}. Let new_fill = min(fill+1, N) and hit = (new_fill==N) && (shifted window == pattern).
  - y <= hit.
  - If hit and overlap=0: fill <= 0.
  - Otherwise: fill <= new_fill.
- s_valid=0, pat_load=0: window and fill hold; y <= 0.
- y is high for exactly one cycle, on the edge that samples the completing bit. Latency: y is visible in the cycle after that bit is presented.
- After a non-overlap hit, window keeps its contents. A new match needs N fresh valid bits, because fill was cleared.
- overlap may change at any time; it is sampled on each valid edge.
- match_count increments on each hit and saturates at 2^COUNT_W-1 (no wrap).

Optional Feature:
- Macro SEQ_DET_COUNT_EN.
- Defined: match_count behaves as described above.
- Undefined: no counter flops; match_count is tied to 0.

Test Plan:
- Default pattern 111, overlap=1, reset released, s_valid=1, s=1,1,1,1,1 -> y pulses after bits 3, 4 and 5 (3 pulses); fill reads 1, 2, 3, 3, 3.
- Same stream with overlap=0 -> single y after bit 3; fill reads 1, 2, 0, 1, 2; no further pulse.
- s=1,1,1 with s_valid=0 for 2 cycles between each bit -> one y, in the cycle after the third valid bit; y=0 during all gap cycles; fill holds across the gaps.
- pat_load with pat_in=3'b101, then s=1,0,1,0,1 -> overlap=1: y after bits 3 and 5; overlap=0: y after bit 3 only. pat_load asserted together with s_valid -> that bit is ignored and fill=0.
- s=1,1, then reset pulsed low between edges -> y=0, fill=0 and window=0 immediately, without a clock edge; after release, s=1 -> no y; fill=1.
- With SEQ_DET_COUNT_EN, COUNT_W=2, overlap=1, six consecutive 1s (4 hits) -> match_count reads 1, 2, 3, 3. Without the macro, match_count=0 throughout.

Source files
------------

// File: rtl/seq_detect_n.sv
// seq_detect_n: parametrised serial sequence detector.
//
// Shifts a valid-qualified serial bit stream into a PATTERN_W-bit window and
// raises a registered one-cycle pulse on y when the window matches the
// programmable pattern register. Overlapping or non-overlapping detection
// is chosen per valid bit by the overlap input.
//
// Optional feature: define SEQ_DET_COUNT_EN to build the saturating match
// counter. Without it, no counter flops exist and match_count is tied to 0.

module seq_detect_n #(
  parameter int                   PATTERN_W = 3,
  parameter logic [PATTERN_W-1:0] PATTERN   = 3'b111,
  parameter int                   COUNT_W   = 8,
  localparam int                  FW        = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s,
  input  logic                 s_valid,
  input  logic                 overlap,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_in,
  output logic                 y,
  output logic [FW-1:0]        fill,
  output logic [PATTERN_W-1:0] window,
  output logic [COUNT_W-1:0]   match_count
);

  // Fill level at which the window holds a complete candidate sequence.
  localparam logic [FW-1:0] FILL_FULL = FW'(PATTERN_W);

  logic [PATTERN_W-1:0] pattern_q;
  logic [PATTERN_W-1:0] window_q;
  logic [FW-1:0]        fill_q;
  logic                 y_q;

  logic [PATTERN_W-1:0] shifted;
  logic [FW-1:0]        new_fill;
  logic                 hit;

  // Next window, saturating fill and match decision for the current bit.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted  = {window_q[PATTERN_W-2:0], s};
    new_fill = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
    hit      = (new_fill == FILL_FULL) && (shifted == pattern_q);
  end

  // Pattern, window, fill and match pulse; pattern reload outranks a data bit.
  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= PATTERN;
      window_q  <= '0;
      fill_q    <= '0;
      y_q       <= 1'b0;
    end else if (pat_load) begin
      // A bit presented alongside a reload belongs to no pattern; drop it.
      pattern_q <= pat_in;
      window_q  <= '0;
      fill_q    <= '0;
      y_q       <= 1'b0;
    end else if (s_valid) begin
      window_q <= shifted;
      y_q      <= hit;
      // Non-overlap restarts the count so the next match needs N fresh bits;
      // the window itself keeps its contents.
      fill_q   <= (hit && !overlap) ? '0 : new_fill;
    end else begin
      y_q <= 1'b0;
    end
  end

  assign y      = y_q;
  assign fill   = fill_q;
  assign window = window_q;

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // Saturating match counter; survives pattern reloads, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (!pat_load && s_valid && hit && (count_q != '1)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_n.sv
// tb_seq_detect_n: directed scoreboard bench for seq_detect_n.
//
// The driver applies one hand-computed vector per clock and pushes the
// expected post-edge outputs into a queue; a monitor on the falling edge
// pops and compares. Asynchronous reset behaviour is checked between edges.
// The DUT is built with COUNT_W=2 so counter saturation is reachable.

module tb_seq_detect_n;

  localparam int N  = 3;
  localparam int CW = 2;
  localparam int FW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s = 1'b0;
  logic          s_valid = 1'b0;
  logic          overlap = 1'b1;
  logic          pat_load = 1'b0;
  logic [N-1:0]  pat_in = '0;
  logic          y;
  logic [FW-1:0] fill;
  logic [N-1:0]  window;
  logic [CW-1:0] match_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic          y;
    logic [FW-1:0] fill;
    logic [N-1:0]  window;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  seq_detect_n #(
    .PATTERN_W(N),
    .PATTERN  (3'b111),
    .COUNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s),
    .s_valid    (s_valid),
    .overlap    (overlap),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .y          (y),
    .fill       (fill),
    .window     (window),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected counter value as seen on the port, given the bench's own count model.
  function automatic logic [CW-1:0] port_cnt();
`ifdef SEQ_DET_COUNT_EN
    return exp_cnt;
`else
    return '0;
`endif
  endfunction

  // One clock of stimulus; expectations are the outputs after that edge.
  task automatic step(input string tag, input logic pl, input logic [N-1:0] pin,
                      input logic v, input logic b, input logic ov,
                      input logic ey, input logic [FW-1:0] ef, input logic [N-1:0] ew);
    exp_t e;
    @(negedge clk);
    pat_load = pl;
    pat_in   = pin;
    s_valid  = v;
    s        = b;
    overlap  = ov;
    @(posedge clk);
    #1;
    if (ey && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
    e.tag    = tag;
    e.y      = ey;
    e.fill   = ef;
    e.window = ew;
    e.cnt    = port_cnt();
    exp_q.push_back(e);
  endtask

  task automatic bit_in(input string tag, input logic b, input logic ov,
                        input logic ey, input logic [FW-1:0] ef, input logic [N-1:0] ew);
    step(tag, 1'b0, '0, 1'b1, b, ov, ey, ef, ew);
  endtask

  task automatic idle(input string tag, input logic ey, input logic [FW-1:0] ef, input logic [N-1:0] ew);
    step(tag, 1'b0, '0, 1'b0, 1'b0, overlap, ey, ef, ew);
  endtask

  // Pulse reset between edges and check the asynchronous clear before any edge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    s_valid  = 1'b0;
    pat_load = 1'b0;
    #2 reset = 1'b0;
    #1;
    check({tag, " y"}, 32'(y), 32'd0);
    check({tag, " fill"}, 32'(fill), 32'd0);
    check({tag, " window"}, 32'(window), 32'd0);
    check({tag, " count"}, 32'(match_count), 32'd0);
    exp_cnt = '0;
    #1 reset = 1'b1;
  endtask

  // Monitor: compare the oldest outstanding expectation on every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " y"}, 32'(y), 32'(e.y));
        check({e.tag, " fill"}, 32'(fill), 32'(e.fill));
        check({e.tag, " window"}, 32'(window), 32'(e.window));
        check({e.tag, " count"}, 32'(match_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    // Reset held from time zero across a couple of edges.
    #23;
    check("por y", 32'(y), 32'd0);
    check("por fill", 32'(fill), 32'd0);
    check("por window", 32'(window), 32'd0);
    check("por count", 32'(match_count), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Default 111, overlap: six 1s -> hits on bits 3..6, counter saturates at 3.
    bit_in("ov b1", 1, 1, 0, 1, 3'b001);
    bit_in("ov b2", 1, 1, 0, 2, 3'b011);
    bit_in("ov b3", 1, 1, 1, 3, 3'b111);
    bit_in("ov b4", 1, 1, 1, 3, 3'b111);
    bit_in("ov b5", 1, 1, 1, 3, 3'b111);
    bit_in("ov b6", 1, 1, 1, 3, 3'b111);
    idle("ov idle", 0, 3, 3'b111);

    // Non-overlap: one hit on bit 3, fill restarts, window kept.
    reset_pulse("rst1");
    bit_in("nov b1", 1, 0, 0, 1, 3'b001);
    bit_in("nov b2", 1, 0, 0, 2, 3'b011);
    bit_in("nov b3", 1, 0, 1, 0, 3'b111);
    bit_in("nov b4", 1, 0, 0, 1, 3'b111);
    bit_in("nov b5", 1, 0, 0, 2, 3'b111);

    // Valid gaps: fill holds, y low during gaps, one pulse after bit 3.
    reset_pulse("rst2");
    bit_in("gap b1", 1, 1, 0, 1, 3'b001);
    idle("gap g1a", 0, 1, 3'b001);
    idle("gap g1b", 0, 1, 3'b001);
    bit_in("gap b2", 1, 1, 0, 2, 3'b011);
    idle("gap g2a", 0, 2, 3'b011);
    idle("gap g2b", 0, 2, 3'b011);
    bit_in("gap b3", 1, 1, 1, 3, 3'b111);
    idle("gap g3a", 0, 3, 3'b111);
    idle("gap g3b", 0, 3, 3'b111);

    // Pattern 101 with overlap: hits on bits 3 and 5.
    reset_pulse("rst3");
    step("load101", 1, 3'b101, 0, 0, 1, 0, 0, 3'b000);
    bit_in("p101o b1", 1, 1, 0, 1, 3'b001);
    bit_in("p101o b2", 0, 1, 0, 2, 3'b010);
    bit_in("p101o b3", 1, 1, 1, 3, 3'b101);
    bit_in("p101o b4", 0, 1, 0, 3, 3'b010);
    bit_in("p101o b5", 1, 1, 1, 3, 3'b101);

    // Reload together with a valid bit: bit dropped, fill and window cleared, count kept.
    step("load+valid", 1, 3'b101, 1, 1, 0, 0, 0, 3'b000);
    bit_in("p101n b1", 1, 0, 0, 1, 3'b001);
    bit_in("p101n b2", 0, 0, 0, 2, 3'b010);
    bit_in("p101n b3", 1, 0, 1, 0, 3'b101);
    bit_in("p101n b4", 0, 0, 0, 1, 3'b010);
    bit_in("p101n b5", 1, 0, 0, 2, 3'b101);

    // Reset mid-sequence: asynchronous clear, then a fresh start.
    reset_pulse("rst4");
    step("load111", 1, 3'b111, 0, 0, 1, 0, 0, 3'b000);
    bit_in("mid b1", 1, 1, 0, 1, 3'b001);
    bit_in("mid b2", 1, 1, 0, 2, 3'b011);
    reset_pulse("rst_mid");
    bit_in("post b1", 1, 1, 0, 1, 3'b001);
    idle("post idle", 0, 1, 3'b001);

    // Drain the scoreboard with a bounded wait.
    repeat (4) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
